// File: rtl/mod2011_unweight.sv
// mod2011_unweight
// Removes a positional weight 2^k from a mod-M residue: res_out = res_in * 2^(-k) mod M.
// One modular halving per clock; valid/ready handshake on both sides.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   request accepted when high (IDLE only)
//   res_in     input residue, any RW-bit value
//   k_in       number of modular halvings
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
//   res_out    result, 0..M-1
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; in_ready=1
// RUN   | one modular halving per edge, cnt counts remaining halvings
// DONE  | result presented on res_out; held until out_ready

module mod2011_unweight #(
    parameter int M  = 2011,
    parameter int RW = 11,
    parameter int KW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RW-1:0] res_in,
    input  logic [KW-1:0] k_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] res_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [RW:0] MOD = M[RW:0];

    state_t        state;
    logic [RW:0]   acc;
    logic [KW-1:0] cnt;

    logic [RW:0]   res_ext;
    logic [RW:0]   res_red;
    logic [RW:0]   acc_sum;

    // 2^RW < 2M, so one conditional subtraction fully reduces any input.
    // acc <= M-1 keeps acc+M within RW+1 bits, and the halved sum stays below M.
    always_comb begin
        res_ext = {1'b0, res_in};
        res_red = (res_ext >= MOD) ? (res_ext - MOD) : res_ext;
        acc_sum = acc + (acc[0] ? MOD : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= res_red;
                        cnt   <= k_in;
                        state <= (k_in == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    acc <= {1'b0, acc_sum[RW:1]};
                    cnt <= cnt - 1'b1;
                    if (cnt == KW'(1))
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign res_out   = acc[RW-1:0];

endmodule

// File: tb/tb_mod2011_unweight.sv
module tb_mod2011_unweight;

    localparam int M  = 2011;
    localparam int RW = 11;
    localparam int KW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [RW-1:0] res_in = '0;
    logic [KW-1:0] k_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [RW-1:0] res_out;

    int n_pass = 0;
    int n_total = 0;

    mod2011_unweight #(.M(M), .RW(RW), .KW(KW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res_in    (res_in),
        .k_in      (k_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_out   (res_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        int k;
        int exp;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: multiply by the modular inverse of 2 (1006) k times.
    function automatic int model(input int res, input int k);
        longint p = 1;
        for (int i = 0; i < k; i++) p = (p * 1006) % M;
        return int'(((res % M) * p) % M);
    endfunction

    function automatic int times_pow2(input int r, input int k);
        longint v = r;
        for (int i = 0; i < k; i++) v = (v * 2) % M;
        return int'(v);
    endfunction

    // Issue one request, wait for the result, check latency; hold out_ready low
    // for 'hold' cycles, then hand off and confirm the return to IDLE.
    task automatic run_req(input int res, input int k, input int hold,
                           output int result, output int lat);
        @(negedge clk);
        chk("in_ready_before_req", in_ready, 1);
        in_valid = 1'b1;
        res_in   = RW'(res);
        k_in     = KW'(k);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        chk("out_valid_seen", out_valid, 1);
        chk("latency", lat, k);
        result = int'(res_out);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_res", res_out, result);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_handoff", {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        vec_t vecs[10];
        int result, lat;

        vecs[0] = '{1, 1, 1006};
        vecs[1] = '{2, 1, 1};
        vecs[2] = '{2047, 0, 36};
        vecs[3] = '{1, 11, 924};
        vecs[4] = '{0, 0, 0};
        vecs[5] = '{2010, 0, 2010};
        vecs[6] = '{2011, 0, 0};
        vecs[7] = '{3, 1, 1007};
        vecs[8] = '{4, 2, 1};
        vecs[9] = '{2047, 1, 18};

        #12;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_res_out", res_out, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_req(vecs[i].res, vecs[i].k, 0, result, lat);
            chk($sformatf("vec%0d_res", i), result, vecs[i].exp);
        end

        // Back-pressure with an ignored request during the hold
        @(negedge clk);
        in_valid = 1'b1; res_in = 11'd1; k_in = 8'd1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_valid_rise", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2); res_in = 11'd77; k_in = 8'd0;
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_res", res_out, 1006);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle", {in_ready, out_valid}, 2'b10);
        chk("bp_res_kept", res_out, 1006);

        // Reset mid-run
        @(negedge clk);
        in_valid = 1'b1; res_in = 11'd5; k_in = 8'd200;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (50) @(negedge clk);
        chk("midrun_busy", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_res_out", res_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_valid", out_valid, 0);
        run_req(0, 200, 0, result, lat);
        chk("post_rst_res", result, 0);

        // Randomized sweep against the reference model
        for (int i = 0; i < 40; i++) begin
            int r, k;
            r = int'($urandom_range(2047, 0));
            k = (i == 0) ? 255 : int'($urandom_range(255, 0));
            run_req(r, k, int'($urandom_range(3, 0)), result, lat);
            chk("rand_model", result, model(r, k));
            chk("rand_range", result < M, 1);
            chk("rand_inverse", times_pow2(result, k), r % M);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
